// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan constants, decoder state type and the letter lookup
// used by every consumer of the keyboard byte stream.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam int         EVT_W           = 6;
    localparam logic [5:0] CODE_UPPER_BASE = 6'd0;
    localparam logic [5:0] CODE_LOWER_BASE = 6'd26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    // Set-2 make code -> letter index 1..26 (A..Z); 0 when the byte is not a letter.
    function automatic logic [4:0] scan_to_letter(input logic [7:0] sc);
        case (sc)
            8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
            8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
            8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
            8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
            8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
            8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
            8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
            8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
            8'h35: return 5'd25;  8'h1A: return 5'd26;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_fifo.sv
// Small synchronous event queue; the head entry is visible combinationally so a
// push into an empty queue is presented on the very next cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok, pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Scan-byte decoder: tracks break/extended prefixes and shift state, and queues
// one letter event per key press for the game FSM.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int REPEAT_EN      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       evt_ready,
    input  logic       clr_overflow,
    output logic       evt_valid,
    output logic [5:0] evt_code,
    output logic       shift_held,
    output logic       overflow
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    dec_state_e    state_reg, state_next;
    logic          shift_l_reg, shift_l_next;
    logic          shift_r_reg, shift_r_next;
    logic [4:0]    last_key_reg, last_key_next;
    logic [TW-1:0] tmo_cnt_reg;
    logic          overflow_reg;

    logic [4:0]    letter_idx;
    logic          tmo_hit;
    logic          push;
    logic [5:0]    push_code;
    logic          fifo_full, fifo_empty;

    assign letter_idx = scan_to_letter(byte_data);
    assign tmo_hit    = (state_reg != IDLE) && !byte_valid
                        && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign shift_held = shift_l_reg | shift_r_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_l_reg  <= 1'b0;
            shift_r_reg  <= 1'b0;
            last_key_reg <= '0;
            tmo_cnt_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_l_reg  <= shift_l_next;
            shift_r_reg  <= shift_r_next;
            last_key_reg <= last_key_next;
            if (state_reg == IDLE || byte_valid || tmo_hit)
                tmo_cnt_reg <= '0;
            else
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            // A drop in the same cycle as a clear leaves the flag set.
            if (push && fifo_full && !evt_ready)
                overflow_reg <= 1'b1;
            else if (clr_overflow)
                overflow_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (byte_valid) begin
            case (state_reg)
                IDLE: begin
                    if (byte_data == SC_BREAK)    state_next = BRK;
                    else if (byte_data == SC_EXT) state_next = EXT;
                end
                EXT:     state_next = (byte_data == SC_BREAK) ? EXT_BRK : IDLE;
                default: state_next = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        shift_l_next  = shift_l_reg;
        shift_r_next  = shift_r_reg;
        last_key_next = last_key_reg;
        push          = 1'b0;
        push_code     = {1'b0, letter_idx} + (shift_held ? CODE_UPPER_BASE : CODE_LOWER_BASE);
        if (byte_valid) begin
            case (state_reg)
                IDLE: begin
                    if (byte_data == SC_LSHIFT) begin
                        shift_l_next = 1'b1;
                    end else if (byte_data == SC_RSHIFT) begin
                        shift_r_next = 1'b1;
                    end else if (letter_idx != 5'd0) begin
                        if (REPEAT_EN != 0 || letter_idx != last_key_reg) begin
                            push          = 1'b1;
                            last_key_next = letter_idx;
                        end
                    end
                end
                BRK: begin
                    if (byte_data == SC_LSHIFT)
                        shift_l_next = 1'b0;
                    else if (byte_data == SC_RSHIFT)
                        shift_r_next = 1'b0;
                    else if (letter_idx != 5'd0 && letter_idx == last_key_reg)
                        last_key_next = 5'd0;
                end
                default: ;
            endcase
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_code),
        .pop       (evt_ready),
        .head_data (evt_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed + random scan-byte stimulus against two controllers (repeat
// suppressed / repeat enabled), compared every cycle with a queue-based model.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    localparam logic [7:0] LETTERS [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;

    logic       ev0, sh0, ov0, ev1, sh1, ov1;
    logic [5:0] code0, code1;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    logic       m_brk, m_ext, m_sl, m_sr;
    int         m_idle;
    logic [4:0] m_last [2];
    logic       m_ovf  [2];
    logic [5:0] mq0 [$];
    logic [5:0] mq1 [$];

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .REPEAT_EN(0)) dut0 (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .clr_overflow(clr_overflow),
        .evt_valid(ev0), .evt_code(code0), .shift_held(sh0), .overflow(ov0));

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .REPEAT_EN(1)) dut1 (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .evt_ready(evt_ready), .clr_overflow(clr_overflow),
        .evt_valid(ev1), .evt_code(code1), .shift_held(sh1), .overflow(ov1));

    function automatic logic [4:0] letter_of(input logic [7:0] b);
        for (int i = 0; i < 26; i++)
            if (LETTERS[i] == b) return 5'(i + 1);
        return 5'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_sl = 0; m_sr = 0; m_idle = 0;
        m_last[0] = 0; m_last[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
        mq0.delete(); mq1.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid0"}, 8'(ev0), 8'(mq0.size() != 0));
        chk({tag, ".code0"}, 8'(code0), (mq0.size() != 0) ? 8'(mq0[0]) : 8'd0);
        chk({tag, ".shift0"}, 8'(sh0), 8'(m_sl | m_sr));
        chk({tag, ".ovf0"}, 8'(ov0), 8'(m_ovf[0]));
        chk({tag, ".valid1"}, 8'(ev1), 8'(mq1.size() != 0));
        chk({tag, ".code1"}, 8'(code1), (mq1.size() != 0) ? 8'(mq1[0]) : 8'd0);
        chk({tag, ".shift1"}, 8'(sh1), 8'(m_sl | m_sr));
        chk({tag, ".ovf1"}, 8'(ov1), 8'(m_ovf[1]));
        $display("[%0t] %s byte=%0b/%02h rdy=%0b -> v0=%0b c0=%0d v1=%0b c1=%0d sh=%0b ov=%0b/%0b",
                 $time, tag, byte_valid, byte_data, evt_ready, ev0, code0, ev1, code1, sh0, ov0, ov1);
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic bv, input logic [7:0] bd,
                        input logic rdy, input logic clr);
        logic [4:0] idx;
        logic [5:0] code;
        logic       push0, push1, pop0, pop1, drop0, drop1;
        byte_valid = bv; byte_data = bd; evt_ready = rdy; clr_overflow = clr;
        idx   = letter_of(bd);
        code  = 6'(idx) + ((m_sl | m_sr) ? 6'd0 : 6'd26);
        push0 = 0; push1 = 0;
        if (bv) begin
            m_idle = 0;
            if (!m_brk && !m_ext) begin
                if (bd == 8'hF0)      m_brk = 1;
                else if (bd == 8'hE0) m_ext = 1;
                else if (bd == 8'h12) m_sl = 1;
                else if (bd == 8'h59) m_sr = 1;
                else if (idx != 0) begin
                    if (idx != m_last[0]) begin push0 = 1; m_last[0] = idx; end
                    push1 = 1; m_last[1] = idx;
                end
            end else if (m_brk && !m_ext) begin
                if (bd == 8'h12)      m_sl = 0;
                else if (bd == 8'h59) m_sr = 0;
                else if (idx != 0) begin
                    if (idx == m_last[0]) m_last[0] = 0;
                    if (idx == m_last[1]) m_last[1] = 0;
                end
                m_brk = 0;
            end else if (m_ext && !m_brk) begin
                if (bd == 8'hF0) m_brk = 1;
                else             m_ext = 0;
            end else begin
                m_brk = 0; m_ext = 0;
            end
        end else if (m_brk || m_ext) begin
            m_idle++;
            if (m_idle == TMO) begin m_brk = 0; m_ext = 0; m_idle = 0; end
        end else begin
            m_idle = 0;
        end
        pop0  = rdy && mq0.size() > 0;
        pop1  = rdy && mq1.size() > 0;
        drop0 = push0 && mq0.size() == DEPTH && !pop0;
        drop1 = push1 && mq1.size() == DEPTH && !pop1;
        if (drop0) m_ovf[0] = 1; else if (clr) m_ovf[0] = 0;
        if (drop1) m_ovf[1] = 1; else if (clr) m_ovf[1] = 0;
        if (pop0) void'(mq0.pop_front());
        if (pop1) void'(mq1.pop_front());
        if (push0 && !drop0) mq0.push_back(code);
        if (push1 && !drop1) mq1.push_back(code);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        step(tag, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle_run;
        logic bv, rdy, clr;
        logic [7:0] b;
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Make, break, make of A
        send("a_mk", 8'h1C); send("a_f0", 8'hF0); send("a_brk", 8'h1C);
        send("a_mk2", 8'h1C);
        drain("a_drain", 3);

        // Shift + B, release shift, B again
        send("s_12", 8'h12); send("s_32", 8'h32); send("s_f0", 8'hF0);
        send("s_rel", 8'h12); send("s_32b", 8'h32);
        drain("s_drain", 3);

        // Typematic repeat
        send("r_1", 8'h1C); send("r_2", 8'h1C); send("r_3", 8'h1C);
        drain("r_drain", 4);
        send("r_f0", 8'hF0); send("r_brk", 8'h1C);

        // Extended sequences, short gap break, timeout-abandoned break
        send("x_e0", 8'hE0); send("x_1c", 8'h1C);
        send("x_e0b", 8'hE0); send("x_f0", 8'hF0); send("x_1cb", 8'h1C);
        send("g_f0", 8'hF0);
        repeat (3) step("g_gap", 1'b0, 8'h00, 1'b0, 1'b0);
        send("g_1c", 8'h1C);
        send("t_f0", 8'hF0);
        repeat (TMO + 2) step("t_wait", 1'b0, 8'h00, 1'b0, 1'b0);
        send("t_1c", 8'h1C);
        drain("t_drain", 2);

        // Overflow: six distinct letters with consumer stalled
        for (int i = 1; i <= 6; i++) send("o_push", LETTERS[i]);
        step("o_clr_busy", 1'b0, 8'h00, 1'b0, 1'b0);
        drain("o_drain", 5);
        step("o_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        step("o_after", 1'b0, 8'h00, 1'b0, 1'b0);

        // Full queue with simultaneous push and pop, plus drop racing a clear
        for (int i = 7; i <= 10; i++) send("f_fill", LETTERS[i]);
        step("f_pushpop", 1'b1, LETTERS[11], 1'b1, 1'b0);
        step("f_dropclr", 1'b1, LETTERS[12], 1'b0, 1'b1);
        step("f_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        send("f_shift", 8'h59);

        // Asynchronous reset mid-stream
        send("m_f0", 8'hF0);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        send("m_1c", 8'h1C);
        drain("m_drain", 2);

        // Randomised traffic; idle runs kept well below the prefix timeout
        idle_run = 0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      b = LETTERS[$urandom_range(0, 5)];
            else if (r < 50) b = 8'h12;
            else if (r < 58) b = 8'h59;
            else if (r < 72) b = 8'hF0;
            else if (r < 80) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            bv  = ($urandom_range(0, 3) != 0) || (idle_run >= 8);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 15) == 0);
            idle_run = bv ? 0 : idle_run + 1;
            step("rand", bv, b, rdy, clr);
        end
        drain("final_drain", 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
